i2s_receiver: RTL and testbench
===============================

// Module: i2s_receiver
// PURPOSE
//  I2S slave receiver for the audio input path (ADC/line-in). Samples external bck/lrck/sdin in the
//  in_clk domain, deserialises 16-bit L/R samples MSB-first, and presents one 32-bit {L,R} frame per
//  lrck period on a valid/ready interface toward the NeXT-side DMA logic. Its wire format is the
//  complement of our I2S transmitter: left on lrck=0, MSB one bck after the lrck edge, upper 16 = left.
// PARAMETERS
//  SAMPLE_W     16  bits per channel captured after each lrck edge
//  SLOT_MAX     32  bck rises per channel slot before the slot counter saturates
//  SYNC_STAGES  2   synchroniser depth on bck/lrck/sdin (>=2)
// PORTS
//  in_clk         in   1   system clock, >= 4x bck frequency
//  reset          in   1   asynchronous, active-high
//  bck            in   1   I2S bit clock (64fs), asynchronous
//  lrck           in   1   I2S word select, 0 = left, 1 = right
//  sdin           in   1   I2S serial data, valid on bck rising edge
//  out_valid      out  1   frame available in out_data
//  out_ready      in   1   consumer accepts frame when out_valid & out_ready
//  out_data       out  32  {left[15:0], right[15:0]}
//  overflow_tick  out  1   1-cycle pulse: completed frame dropped, previous frame still pending
//  sync_err_tick  out  1   1-cycle pulse: lrck edge arrived before SAMPLE_W bits were captured
//  locked         out  1   high after the first complete L+R frame; cleared by reset or sync error
// BEHAVIOUR
//  - Reset (async, active-high): all outputs 0; slot counter, shift register and left buffer cleared;
//    the frame pending on out_data is discarded. A reset mid-slot discards the partial sample; the first
//    frame after reset requires a full left slot followed by a full right slot.
//  - Input path: SYNC_STAGES FFs on each input; bck_rise = bck_s & ~bck_s_d (one in_clk pulse).
//    All state below advances only on bck_rise cycles.
//  - On bck_rise with lrck_s != lrck_prev: start a new slot. Set bit_cnt = 0 and latch ch = lrck_s.
//    If the previous slot held fewer than SAMPLE_W bits, pulse sync_err_tick, clear locked and drop the
//    held left sample. The sdin sampled on this rise belongs to the previous slot and is ignored.
//  - Otherwise: bit_cnt = min(bit_cnt+1, SLOT_MAX). When the new bit_cnt is 1..SAMPLE_W, shift
//    sdin_s into shreg LSB (MSB first). Bits after SAMPLE_W are ignored.
//  - When bit_cnt reaches SAMPLE_W:
//    - ch=L: latch left_buf and set left_ok.
//    - ch=R with left_ok: the frame {left_buf, shreg} is complete; clear left_ok and set locked.
//    - ch=R without left_ok: discard the sample, which aligns frames to start on a left slot.
//  - Output register: a complete frame loads out_data and sets out_valid on the next in_clk edge.
//    Latency is <= SYNC_STAGES+2 in_clk from the bck edge that carried the right LSB.
//    out_valid falls the cycle after out_valid & out_ready, unless a new frame loads that same cycle
//    (accept and load together is legal: out_valid stays 1 with the new data).
//    If a frame completes while out_valid & ~out_ready: keep the old frame, drop the new one, and pulse
//    overflow_tick.
//  - out_data and out_valid are stable while out_valid & ~out_ready.
//  - No bck activity: the state holds and out_valid persists until accepted.
// CONFIGURATION
//  `I2S_RX_DECIM_EN defined: adds input decim_22k_in (1 = 22.05 kHz output).
//    - When high, frames are paired. out_data = per-channel (a+b)>>>1, computed as a signed 17-bit sum
//      and truncated to 16 bits; one output per two frames.
//    - A change of decim_22k_in takes effect at the next left-slot start and resets the pair phase.
//    - sync_err also resets the pair phase.
//  Macro undefined: port absent; every frame is emitted unaltered (44.1 kHz).
// STRUCTURE
//  Shared defines file i2s_defs.vh: CH_L=1'b0, CH_R=1'b1, I2S_SAMPLE_W=16, I2S_FRAME_W=32.
//    Our transmitter uses the same constants.
//  Sub-module i2s_rx_sync: SYNC_STAGES synchroniser for bck/lrck/sdin plus bck_rise edge detect.
//  The top level holds the slot counter, shift register, framer and output register.
// TESTING
//  - Bench drives the bck/lrck/sdin format at 400 ns bck against a 40 ns in_clk.
//  - Frame: L=16'hD999, R=16'h9993, out_ready=1 -> exactly one out_valid pulse with
//    out_data=32'hD9999993, locked=1.
//  - Start mid right slot after reset -> partial right and first full right before any left are
//    discarded; the first out_data is the next complete L+R.
//  - out_ready=0 across two frames -> first frame held unchanged, overflow_tick pulses once.
//    Raise out_ready -> first frame accepted, out_valid=0.
//  - Flip lrck after 9 bits of a left slot -> sync_err_tick pulses, locked=0, no frame emitted;
//    the next clean L+R frame is emitted.
//  - Assert reset mid right slot, then release -> all outputs 0; the next frame out is the first full
//    L+R after release.
//  - With I2S_RX_DECIM_EN and decim_22k_in=1, frames {16'h0004,16'hFFFC} then {16'h0002,16'hFFFE}
//    -> one output 32'h0003FFFD.

Source files
------------

// File: rtl/i2s_receiver_pkg.sv
// Shared constants and helpers for the I2S slave receiver.
// The channel codes and sample/frame widths are the same ones the I2S transmitter uses.
package i2s_receiver_pkg;

    localparam int   I2S_SAMPLE_W = 16;
    localparam int   I2S_FRAME_W  = 32;
    localparam logic CH_L         = 1'b0;
    localparam logic CH_R         = 1'b1;

    // Average of two signed 16-bit samples: a signed 17-bit sum, shifted right arithmetically by one.
    function automatic logic [15:0] avg_s16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {a[15], a} + {b[15], b};
        return sum[16:1];
    endfunction

endpackage

// File: rtl/i2s_rx_sync.sv
// Input synchroniser for the external I2S pins, plus a bck rising-edge detector.
// bck, lrck and sdin go through chains of equal depth, so all three stay time-aligned.
module i2s_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic in_clk,
    input  logic reset,
    input  logic bck,
    input  logic lrck,
    input  logic sdin,
    output logic bck_rise,
    output logic lrck_s,
    output logic sdin_s
);

    logic [SYNC_STAGES-1:0] bck_sync_q;
    logic [SYNC_STAGES-1:0] lrck_sync_q;
    logic [SYNC_STAGES-1:0] sdin_sync_q;
    logic                   bck_dly_q;

    // Shift the external pins through the synchroniser chains and hold the previous bck.
    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            bck_sync_q  <= '0;
            lrck_sync_q <= '0;
            sdin_sync_q <= '0;
            bck_dly_q   <= 1'b0;
        end else begin
            bck_sync_q  <= {bck_sync_q[SYNC_STAGES-2:0], bck};
            lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], lrck};
            sdin_sync_q <= {sdin_sync_q[SYNC_STAGES-2:0], sdin};
            bck_dly_q   <= bck_sync_q[SYNC_STAGES-1];
        end
    end

    assign bck_rise = bck_sync_q[SYNC_STAGES-1] & ~bck_dly_q;
    assign lrck_s   = lrck_sync_q[SYNC_STAGES-1];
    assign sdin_s   = sdin_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_receiver.sv
// I2S slave receiver: deserialises 16-bit left/right samples (MSB first, left on lrck=0) and
// presents one {left,right} frame per lrck period on a valid/ready interface.
// Optional feature: define I2S_RX_DECIM_EN to add decim_22k_in. When it is high, pairs of
// frames are averaged per channel, giving one output per two frames.
module i2s_receiver
    import i2s_receiver_pkg::*;
#(
    parameter int SAMPLE_W    = I2S_SAMPLE_W,
    parameter int SLOT_MAX    = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  in_clk,
    input  logic                  reset,
    input  logic                  bck,
    input  logic                  lrck,
    input  logic                  sdin,
`ifdef I2S_RX_DECIM_EN
    input  logic                  decim_22k_in,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*SAMPLE_W-1:0] out_data,
    output logic                  overflow_tick,
    output logic                  sync_err_tick,
    output logic                  locked
);

    localparam int             CNT_W      = $clog2(SLOT_MAX + 1);
    localparam int             FW         = 2 * SAMPLE_W;
    localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_W);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(SLOT_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic bck_rise_s;
    logic lrck_s;
    logic sdin_s;

    i2s_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .in_clk   (in_clk),
        .reset    (reset),
        .bck      (bck),
        .lrck     (lrck),
        .sdin     (sdin),
        .bck_rise (bck_rise_s),
        .lrck_s   (lrck_s),
        .sdin_s   (sdin_s)
    );

    // Framer state. primed: lrck_prev holds a real sample. slot_act: a true slot start has been seen
    // since reset, so bits are counted and short slots count as sync errors.
    logic                primed_q,    primed_d;
    logic                slot_act_q,  slot_act_d;
    logic                lrck_prev_q, lrck_prev_d;
    logic                ch_q,        ch_d;
    logic [CNT_W-1:0]    bit_cnt_q,   bit_cnt_d;
    logic [SAMPLE_W-1:0] shreg_q,     shreg_d;
    logic [SAMPLE_W-1:0] left_buf_q,  left_buf_d;
    logic                left_ok_q,   left_ok_d;
    logic                locked_q,    locked_d;
    logic                sync_err_q,  sync_err_d;
    logic [CNT_W-1:0]    cnt_n_s;
    logic                emit_s;
    logic [FW-1:0]       emit_data_s;

    // Output register state.
    logic                out_valid_q, out_valid_d;
    logic [FW-1:0]       out_data_q,  out_data_d;
    logic                ovf_q,       ovf_d;

`ifdef I2S_RX_DECIM_EN
    logic                decim_q,     decim_d;
    logic                phase_q,     phase_d;
    logic [FW-1:0]       pair_q,      pair_d;
`endif

    // Slot counting, shifting, framing and (optionally) pair decimation; advances on bck rises only.
    always_comb begin
        primed_d    = primed_q;
        slot_act_d  = slot_act_q;
        lrck_prev_d = lrck_prev_q;
        ch_d        = ch_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        left_buf_d  = left_buf_q;
        left_ok_d   = left_ok_q;
        locked_d    = locked_q;
        sync_err_d  = 1'b0;
        cnt_n_s     = bit_cnt_q;
        emit_s      = 1'b0;
        emit_data_s = {left_buf_q, shreg_q};
`ifdef I2S_RX_DECIM_EN
        decim_d     = decim_q;
        phase_d     = phase_q;
        pair_d      = pair_q;
`endif
        if (bck_rise_s) begin
            lrck_prev_d = lrck_s;
            primed_d    = 1'b1;
            if (!primed_q) begin
                // First rise after reset only establishes the lrck reference.
                bit_cnt_d = '0;
            end else if (lrck_s != lrck_prev_q) begin
                bit_cnt_d  = '0;
                ch_d       = lrck_s;
                slot_act_d = 1'b1;
                if (slot_act_q && (bit_cnt_q < CNT_SAMPLE)) begin
                    sync_err_d = 1'b1;
                    locked_d   = 1'b0;
                    left_ok_d  = 1'b0;
`ifdef I2S_RX_DECIM_EN
                    phase_d    = 1'b0;
`endif
                end else begin
                    sync_err_d = 1'b0;
                end
`ifdef I2S_RX_DECIM_EN
                if ((lrck_s == CH_L) && (decim_22k_in != decim_q)) begin
                    decim_d = decim_22k_in;
                    phase_d = 1'b0;
                end else begin
                    decim_d = decim_q;
                end
`endif
            end else if (slot_act_q) begin
                cnt_n_s   = (bit_cnt_q >= CNT_MAX) ? CNT_MAX : (bit_cnt_q + CNT_ONE);
                bit_cnt_d = cnt_n_s;
                if ((cnt_n_s >= CNT_ONE) && (cnt_n_s <= CNT_SAMPLE)) begin
                    shreg_d = {shreg_q[SAMPLE_W-2:0], sdin_s};
                end else begin
                    shreg_d = shreg_q;
                end
                if (cnt_n_s == CNT_SAMPLE) begin
                    if (ch_q == CH_L) begin
                        left_buf_d = shreg_d;
                        left_ok_d  = 1'b1;
                    end else if (left_ok_q) begin
                        left_ok_d   = 1'b0;
                        locked_d    = 1'b1;
                        emit_data_s = {left_buf_q, shreg_d};
`ifdef I2S_RX_DECIM_EN
                        if (decim_q) begin
                            if (!phase_q) begin
                                pair_d  = {left_buf_q, shreg_d};
                                phase_d = 1'b1;
                                emit_s  = 1'b0;
                            end else begin
                                phase_d     = 1'b0;
                                emit_s      = 1'b1;
                                emit_data_s = {avg_s16(pair_q[FW-1:SAMPLE_W], left_buf_q),
                                               avg_s16(pair_q[SAMPLE_W-1:0], shreg_d)};
                            end
                        end else begin
                            emit_s = 1'b1;
                        end
`else
                        emit_s = 1'b1;
`endif
                    end else begin
                        // Right sample with no held left: drop it so frames start on a left slot.
                        left_ok_d = 1'b0;
                    end
                end else begin
                    left_ok_d = left_ok_q;
                end
            end else begin
                bit_cnt_d = bit_cnt_q;
            end
        end else begin
            primed_d = primed_q;
        end
    end

    // Output register: load a new frame unless the pending one is still unaccepted.
    always_comb begin
        out_valid_d = out_valid_q & ~out_ready;
        out_data_d  = out_data_q;
        ovf_d       = 1'b0;
        if (emit_s) begin
            if (out_valid_q && !out_ready) begin
                ovf_d = 1'b1;
            end else begin
                out_data_d  = emit_data_s;
                out_valid_d = 1'b1;
            end
        end else begin
            ovf_d = 1'b0;
        end
    end

    // State and output flops.
    always_ff @(posedge in_clk or posedge reset) begin
        if (reset) begin
            primed_q    <= 1'b0;
            slot_act_q  <= 1'b0;
            lrck_prev_q <= 1'b0;
            ch_q        <= CH_L;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            left_buf_q  <= '0;
            left_ok_q   <= 1'b0;
            locked_q    <= 1'b0;
            sync_err_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ovf_q       <= 1'b0;
`ifdef I2S_RX_DECIM_EN
            decim_q     <= 1'b0;
            phase_q     <= 1'b0;
            pair_q      <= '0;
`endif
        end else begin
            primed_q    <= primed_d;
            slot_act_q  <= slot_act_d;
            lrck_prev_q <= lrck_prev_d;
            ch_q        <= ch_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            left_buf_q  <= left_buf_d;
            left_ok_q   <= left_ok_d;
            locked_q    <= locked_d;
            sync_err_q  <= sync_err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ovf_q       <= ovf_d;
`ifdef I2S_RX_DECIM_EN
            decim_q     <= decim_d;
            phase_q     <= phase_d;
            pair_q      <= pair_d;
`endif
        end
    end

    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign overflow_tick = ovf_q;
    assign sync_err_tick = sync_err_q;
    assign locked        = locked_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// Scoreboard bench for i2s_receiver: stimulus pushes expected frames into a queue, a monitor
// pops and compares on every accepted output. Decimation case runs when I2S_RX_DECIM_EN is defined.
module tb_i2s_receiver;

    logic        in_clk = 1'b0;
    logic        reset  = 1'b1;
    logic        bck    = 1'b1;
    logic        lrck   = 1'b1;
    logic        sdin   = 1'b0;
    logic        out_ready = 1'b1;
    logic        out_valid;
    logic [31:0] out_data;
    logic        overflow_tick;
    logic        sync_err_tick;
    logic        locked;
`ifdef I2S_RX_DECIM_EN
    logic        decim_22k_in = 1'b0;
`endif

    logic [31:0] exp_q[$];
    int          n_cmp  = 0;
    int          n_bad  = 0;
    int          ovf_cnt  = 0;
    int          serr_cnt = 0;

    i2s_receiver dut (
        .in_clk        (in_clk),
        .reset         (reset),
        .bck           (bck),
        .lrck          (lrck),
        .sdin          (sdin),
`ifdef I2S_RX_DECIM_EN
        .decim_22k_in  (decim_22k_in),
`endif
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .overflow_tick (overflow_tick),
        .sync_err_tick (sync_err_tick),
        .locked        (locked)
    );

    always #20 in_clk = ~in_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every accepted frame against the scoreboard and count status pulses.
    always @(negedge in_clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL frame: got %h expected none (unexpected frame)", out_data);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        n_bad++;
                        $display("FAIL frame: got %h expected %h", out_data, e);
                    end
                end
            end
            if (overflow_tick) ovf_cnt++;
            if (sync_err_tick) serr_cnt++;
        end
    end

    task automatic bck_cycle(input logic lr, input logic d);
        bck  = 1'b0;
        lrck = lr;
        sdin = d;
        #200;
        bck  = 1'b1;
        #200;
    endtask

    // One channel slot of nper bck periods: period 0 is the lrck edge, periods 1..16 carry MSB..LSB.
    task automatic slot(input logic lr, input logic [15:0] data, input int nper);
        for (int j = 0; j < nper; j++) begin
            logic d;
            d = ((j >= 1) && (j <= 16)) ? data[16-j] : 1'b0;
            bck_cycle(lr, d);
        end
    endtask

    task automatic frame(input logic [15:0] l, input logic [15:0] r);
        slot(1'b0, l, 32);
        slot(1'b1, r, 32);
    endtask

    task automatic wait_clks(input int n);
        for (int i = 0; i < n; i++) @(negedge in_clk);
    endtask

    initial begin
        // Reset state
        wait_clks(5);
        check("rst_valid",    {31'd0, out_valid},     32'd0);
        check("rst_data",     out_data,               32'd0);
        check("rst_ovf",      {31'd0, overflow_tick}, 32'd0);
        check("rst_serr",     {31'd0, sync_err_tick}, 32'd0);
        check("rst_locked",   {31'd0, locked},        32'd0);
        reset = 1'b0;
        wait_clks(2);

        // Start mid right slot: partial right is ignored, first L+R is the first frame
        slot(1'b1, 16'hAAAA, 20);
        exp_q.push_back(32'hD9999993);
        frame(16'hD999, 16'h9993);
        wait_clks(5);
        check("locked_after_frame", {31'd0, locked}, 32'd1);
        check("no_serr_startup",    serr_cnt,        32'd0);

        exp_q.push_back(32'h12345678);
        frame(16'h1234, 16'h5678);

        // Overflow: hold ready low across two frames
        @(posedge in_clk); #1 out_ready = 1'b0;
        exp_q.push_back(32'hA5A55A5A);
        frame(16'hA5A5, 16'h5A5A);
        frame(16'h0F0F, 16'hF0F0);
        wait_clks(5);
        check("ovf_count",  ovf_cnt,                32'd1);
        check("held_valid", {31'd0, out_valid},     32'd1);
        check("held_data",  out_data,               32'h A5A55A5A);
        @(posedge in_clk); #1 out_ready = 1'b1;
        wait_clks(3);
        check("valid_after_accept", {31'd0, out_valid}, 32'd0);

        // Sync error: lrck flips after 9 bits of a left slot; the following right is discarded
        slot(1'b0, 16'hFFFF, 10);
        slot(1'b1, 16'h7777, 32);
        check("serr_count",  serr_cnt,           32'd1);
        check("locked_serr", {31'd0, locked},    32'd0);
        exp_q.push_back(32'h43218765);
        frame(16'h4321, 16'h8765);
        check("locked_relock", {31'd0, locked},  32'd1);

        // Reset mid right slot
        slot(1'b0, 16'hBEEF, 32);
        slot(1'b1, 16'hCAFE, 10);
        reset = 1'b1;
        wait_clks(3);
        check("mid_rst_valid",  {31'd0, out_valid},     32'd0);
        check("mid_rst_data",   out_data,               32'd0);
        check("mid_rst_locked", {31'd0, locked},        32'd0);
        check("mid_rst_ovf",    {31'd0, overflow_tick}, 32'd0);
        check("mid_rst_serr",   {31'd0, sync_err_tick}, 32'd0);
        reset = 1'b0;
        wait_clks(2);
        slot(1'b1, 16'hCAFE, 22);
        exp_q.push_back(32'hC0010DD5);
        frame(16'hC001, 16'h0DD5);
        check("serr_total", serr_cnt, 32'd1);

`ifdef I2S_RX_DECIM_EN
        // Decimation: two frames averaged per channel
        decim_22k_in = 1'b1;
        exp_q.push_back(32'h0003FFFD);
        frame(16'h0004, 16'hFFFC);
        frame(16'h0002, 16'hFFFE);
`endif

        wait_clks(20);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        check("ovf_total",          ovf_cnt,      32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
